video_scandoubler: RTL

- Consumes the raster counters and strobes of the video sync generator.
- Stores each 7 MHz TV-rate pixel line into a two-bank line buffer and replays it twice at 14 MHz for VGA output.
- In TV mode it bypasses the buffer with matched, fixed latency.
- Sits between the pixel/palette pipeline (upstream) and the video DAC output registers (downstream).

---
 rtl/video_scandoubler.sv | 103 ++++++++++
 1 files changed

// File: rtl/video_scandoubler.sv
// Scandoubler: buffers each TV-rate line in a two-bank RAM and replays it twice at
// VGA rate, or forwards TV pixels with a matched two-strobe delay.
module video_scandoubler #(
  parameter int              PIX_W     = 16,
  parameter logic [PIX_W-1:0] BLANK_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             c3,
  input  logic             f1,
  input  logic             vga_on,
  input  logic [PIX_W-1:0] pix_in,
  input  logic             pix_we,
  input  logic [9:0]       vga_cnt_in,
  input  logic [9:0]       vga_cnt_out,
  input  logic             tv_blank,
  input  logic             vga_blank,
  input  logic             hsync_in,
  input  logic             vsync_in,
  input  logic             csync_in,
  input  logic             err_clr,
  output logic [PIX_W-1:0] pix_out,
  output logic             hsync_out,
  output logic             vsync_out,
  output logic             csync_out,
  output logic             err_bank
);

  typedef struct packed {
    logic blank;
    logic hsync;
    logic vsync;
    logic csync;
  } ctl_t;

  logic [PIX_W-1:0] mem [1024];
  logic [PIX_W-1:0] rd_q, d1_pix;
  ctl_t             ctl_in, d1;
  logic             mode_r, mode_q, mode_chg, adv, flush, err_set;
  logic [1:0]       flush_cnt;

  // Buffer RAM carries no reset; reads see pre-write data on a same-address hit.
  always_ff @(posedge clk) begin
    if (c3 && pix_we) mem[vga_cnt_in] <= pix_in;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)  rd_q <= '0;
    else if (f1) rd_q <= mem[vga_cnt_out];
  end

  assign mode_chg = mode_r ^ mode_q;
  assign adv      = mode_r ? f1 : c3;
  // Output is blanked for the first two strobes of a newly selected mode.
  assign flush    = mode_chg || (flush_cnt != 2'd0);
  assign err_set  = c3 && pix_we && f1 && (vga_cnt_in[9] == vga_cnt_out[9]) && mode_r;

  always_comb begin
    ctl_in       = '0;
    ctl_in.blank = mode_r ? vga_blank : tv_blank;
    ctl_in.hsync = hsync_in;
    ctl_in.vsync = vsync_in;
    ctl_in.csync = csync_in;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_r    <= 1'b0;
      mode_q    <= 1'b0;
      flush_cnt <= 2'd0;
    end else begin
      mode_r <= vga_on;
      mode_q <= mode_r;
      if (mode_chg)                         flush_cnt <= adv ? 2'd1 : 2'd2;
      else if (adv && flush_cnt != 2'd0)    flush_cnt <= flush_cnt - 2'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      d1        <= '0;
      d1_pix    <= '0;
      pix_out   <= BLANK_VAL;
      hsync_out <= 1'b0;
      vsync_out <= 1'b0;
      csync_out <= 1'b0;
    end else if (adv) begin
      d1        <= ctl_in;
      d1_pix    <= pix_in;
      pix_out   <= (flush || d1.blank) ? BLANK_VAL : (mode_r ? rd_q : d1_pix);
      hsync_out <= d1.hsync;
      vsync_out <= d1.vsync;
      csync_out <= d1.csync;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                 err_bank <= 1'b0;
    else if (err_set)           err_bank <= 1'b1;
    else if (err_clr && mode_r) err_bank <= 1'b0;
  end

endmodule
